// File: rtl/pipe_arb_pkg.sv
// Shared definitions for the pipelined priority arbiter: FSM encoding and default width.
package pipe_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_DEFAULT_N = 8;

endpackage

// File: rtl/prio_find.sv
// Combinational circular search: first set bit of vec at or above start, wrapping N-1 -> 0.
module prio_find
    import pipe_arb_pkg::*;
#(
    parameter int N = ARB_DEFAULT_N,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] index
);

    int pos;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = (int'(start) + k) % N;
            if (vec[pos]) begin
                found = 1'b1;
                index = W'(pos);
            end
        end
    end

endmodule

// File: rtl/pipe_prio_arbiter.sv
// Pipelined arbiter with registered grant and back-to-back re-arbitration on ack.
// Define PIPE_ARB_ROUND_ROBIN_EN for round-robin order; default is fixed priority (bit 0 highest).
module pipe_prio_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int N = ARB_DEFAULT_N,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic         stall
);

    arb_state_t   state;
    arb_state_t   state_next;
    logic [W-1:0] idx_next;
    logic [N-1:0] idx_mask;
    logic [N-1:0] search_vec;
    logic [W-1:0] start;
    logic [W-1:0] win_idx;
    logic         found;

    // While granting, the current holder is excluded so an ack hands off to someone else.
    assign idx_mask   = {{(N-1){1'b0}}, 1'b1} << idx;
    assign search_vec = (state == ARB_GRANT) ? (req & ~idx_mask) : req;

`ifdef PIPE_ARB_ROUND_ROBIN_EN
    logic [W-1:0] ptr;
    logic [W-1:0] idx_inc;

    assign idx_inc = (idx == W'(N - 1)) ? '0 : idx + 1'b1;
    assign start   = (state == ARB_GRANT) ? idx_inc : ptr;

    // Pointer only advances on an accepted ack; a flush (en low) does not count as acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (state == ARB_GRANT && en && ack) begin
            ptr <= idx_inc;
        end
    end
`else
    assign start = '0;
`endif

    prio_find #(
        .N(N),
        .W(W)
    ) u_find (
        .vec  (search_vec),
        .start(start),
        .found(found),
        .index(win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ARB_IDLE: begin
                if (en && found) begin
                    state_next = ARB_GRANT;
                    idx_next   = win_idx;
                end
            end
            ARB_GRANT: begin
                if (!en) begin
                    state_next = ARB_IDLE;
                end else if (ack) begin
                    if (found) begin
                        idx_next = win_idx;
                    end else begin
                        state_next = ARB_IDLE;
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign valid = (state == ARB_GRANT);
    assign stall = valid | (en & (|req));

endmodule

// File: tb/tb_pipe_prio_arbiter.sv
// Self-checking bench for pipe_prio_arbiter (N=8) using a queue of expected grant states.
module tb_pipe_prio_arbiter;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic         en;
    logic [N-1:0] req;
    logic         ack;
    logic         valid;
    logic [W-1:0] idx;
    logic         stall;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] idx;
        logic         chk_idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_compared;
    int   n_failed;

    pipe_prio_arbiter #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .req  (req),
        .ack  (ack),
        .valid(valid),
        .idx  (idx),
        .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired, got no summary, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e_en, input logic [N-1:0] e_req, input logic e_ack);
        en  = e_en;
        req = e_req;
        ack = e_ack;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 8'hFF, 1'b0);
        #3;
        n_compared++;
        if (valid !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL reset_valid: got %b, required 0", valid);
        end
        n_compared++;
        if (idx !== 3'd0) begin
            n_failed++;
            $display("[TB] FAIL reset_idx: got %0d, required 0", idx);
        end
        n_compared++;
        if (stall !== 1'b1) begin
            n_failed++;
            $display("[TB] FAIL reset_stall: got %b, required 1", stall);
        end
        tick();
        rst = 1'b0;
        exp_q.push_back('{valid: 1'b1, idx: 3'd0, chk_idx: 1'b1});
        tick();
        e = exp_q.pop_front();
        n_compared++;
        if (valid !== e.valid || idx !== e.idx) begin
            n_failed++;
            $display("[TB] FAIL first_grant: got valid=%b idx=%0d, required valid=%b idx=%0d", valid, idx, e.valid, e.idx);
        end
    endtask

    task automatic test_fixed_priority();
        logic [N-1:0] reqs [3];
        logic         acks [3];
        reqs = '{8'b1010_0000, 8'b1000_0000, 8'h00};
        acks = '{1'b0, 1'b1, 1'b1};
        do_reset();
        exp_q.push_back('{valid: 1'b1, idx: 3'd5, chk_idx: 1'b1});
        exp_q.push_back('{valid: 1'b1, idx: 3'd7, chk_idx: 1'b1});
        exp_q.push_back('{valid: 1'b0, idx: 3'd0, chk_idx: 1'b0});
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, reqs[s], acks[s]);
            tick();
            e = exp_q.pop_front();
            n_compared++;
            if (valid !== e.valid || (e.chk_idx && idx !== e.idx)) begin
                n_failed++;
                $display("[TB] FAIL fixed_step%0d: got valid=%b idx=%0d, required valid=%b idx=%0d", s, valid, idx, e.valid, e.idx);
            end
        end
        drive(1'b1, 8'h00, 1'b0);
        #1;
        n_compared++;
        if (stall !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL idle_no_req_stall: got %b, required 0", stall);
        end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1'b1, 8'h08, 1'b0);
        exp_q.push_back('{valid: 1'b1, idx: 3'd3, chk_idx: 1'b1});
        tick();
        for (int s = 0; s < 5; s++) begin
            drive(1'b1, (s % 2 == 0) ? 8'h01 : 8'h81, 1'b0);
            exp_q.push_back('{valid: 1'b1, idx: 3'd3, chk_idx: 1'b1});
            if (s == 0) begin
                e = exp_q.pop_front();
                n_compared++;
                if (valid !== e.valid || idx !== e.idx) begin
                    n_failed++;
                    $display("[TB] FAIL hold_grant: got valid=%b idx=%0d, required valid=%b idx=%0d", valid, idx, e.valid, e.idx);
                end
            end
            tick();
            e = exp_q.pop_front();
            n_compared++;
            if (valid !== e.valid || idx !== e.idx) begin
                n_failed++;
                $display("[TB] FAIL hold_cycle%0d: got valid=%b idx=%0d, required valid=%b idx=%0d", s, valid, idx, e.valid, e.idx);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 8'h04, 1'b0);
        exp_q.push_back('{valid: 1'b1, idx: 3'd2, chk_idx: 1'b1});
        tick();
        e = exp_q.pop_front();
        n_compared++;
        if (valid !== e.valid || idx !== e.idx) begin
            n_failed++;
            $display("[TB] FAIL flush_grant: got valid=%b idx=%0d, required valid=%b idx=%0d", valid, idx, e.valid, e.idx);
        end
        drive(1'b0, 8'h04, 1'b1);
        exp_q.push_back('{valid: 1'b0, idx: 3'd0, chk_idx: 1'b0});
        tick();
        e = exp_q.pop_front();
        n_compared++;
        if (valid !== e.valid) begin
            n_failed++;
            $display("[TB] FAIL flush_valid: got %b, required %b", valid, e.valid);
        end
        n_compared++;
        if (stall !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL flush_stall: got %b, required 0", stall);
        end
        drive(1'b1, 8'h00, 1'b1);
        exp_q.push_back('{valid: 1'b0, idx: 3'd0, chk_idx: 1'b0});
        tick();
        e = exp_q.pop_front();
        n_compared++;
        if (valid !== e.valid) begin
            n_failed++;
            $display("[TB] FAIL idle_ack_ignored: got valid=%b, required %b", valid, e.valid);
        end
        drive(1'b1, 8'h04, 1'b1);
        exp_q.push_back('{valid: 1'b1, idx: 3'd2, chk_idx: 1'b1});
        tick();
        e = exp_q.pop_front();
        n_compared++;
        if (valid !== e.valid || idx !== e.idx) begin
            n_failed++;
            $display("[TB] FAIL regrant_after_flush: got valid=%b idx=%0d, required valid=%b idx=%0d", valid, idx, e.valid, e.idx);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] want;
        do_reset();
        drive(1'b1, 8'hFF, 1'b0);
        exp_q.push_back('{valid: 1'b1, idx: 3'd0, chk_idx: 1'b1});
        tick();
        e = exp_q.pop_front();
        n_compared++;
        if (valid !== e.valid || idx !== e.idx) begin
            n_failed++;
            $display("[TB] FAIL b2b_first: got valid=%b idx=%0d, required valid=%b idx=%0d", valid, idx, e.valid, e.idx);
        end
        for (int k = 0; k < 9; k++) begin
`ifdef PIPE_ARB_ROUND_ROBIN_EN
            want = W'((k + 1) % N);
`else
            want = (k % 2 == 0) ? 3'd1 : 3'd0;
`endif
            drive(1'b1, 8'hFF, 1'b1);
            exp_q.push_back('{valid: 1'b1, idx: want, chk_idx: 1'b1});
            tick();
            e = exp_q.pop_front();
            n_compared++;
            if (valid !== e.valid || idx !== e.idx) begin
                n_failed++;
                $display("[TB] FAIL b2b_ack%0d: got valid=%b idx=%0d, required valid=%b idx=%0d", k, valid, idx, e.valid, e.idx);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 8'h10, 1'b0);
        exp_q.push_back('{valid: 1'b1, idx: 3'd4, chk_idx: 1'b1});
        tick();
        e = exp_q.pop_front();
        n_compared++;
        if (valid !== e.valid || idx !== e.idx) begin
            n_failed++;
            $display("[TB] FAIL async_pre_grant: got valid=%b idx=%0d, required valid=%b idx=%0d", valid, idx, e.valid, e.idx);
        end
        #2;
        rst = 1'b1;
        #1;
        n_compared++;
        if (valid !== 1'b0 || idx !== 3'd0) begin
            n_failed++;
            $display("[TB] FAIL async_drop: got valid=%b idx=%0d, required valid=0 idx=0", valid, idx);
        end
        #1;
        rst = 1'b0;
        exp_q.push_back('{valid: 1'b1, idx: 3'd4, chk_idx: 1'b1});
        tick();
        e = exp_q.pop_front();
        n_compared++;
        if (valid !== e.valid || idx !== e.idx) begin
            n_failed++;
            $display("[TB] FAIL async_regrant: got valid=%b idx=%0d, required valid=%b idx=%0d", valid, idx, e.valid, e.idx);
        end
    endtask

    initial begin
        n_compared = 0;
        n_failed   = 0;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        test_reset();
        test_fixed_priority();
        test_hold();
        test_flush();
        test_back_to_back();
        test_async_reset();
        if (exp_q.size() != 0) begin
            n_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
